// File: rtl/softmax_pkg.sv
// Shared types and widths for the fully-connected MAC engine: FSM states,
// Q8.8 / Q16.16 datapath widths and the 32-bit saturation limits.
package softmax_pkg;

    localparam int DATA_W = 16;
    localparam int PROD_W = 32;
    localparam int ACC_W  = 48;
    localparam int WORD_W = 32;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 48'sh0000_7FFF_FFFF;
    localparam logic signed [ACC_W-1:0] SAT_MIN = 48'shFFFF_8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIAS,
        ST_MAC,
        ST_DRAIN,
        ST_WRITE,
        ST_FIN
    } state_t;

    // Address width that stays legal for a depth of 1.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fc_mac_pipe.sv
// Datapath of the FC engine: registered 16x16 signed product, 48-bit
// accumulator loaded from the bias word, and saturation of the result to 32 bits.
module fc_mac_pipe import softmax_pkg::*; (
    input  logic              clk,
    input  logic              reset_x,
    input  logic              bias_rd,
    input  logic              mac_rd,
    input  logic [WORD_W-1:0] bias_rdata,
    input  logic [WORD_W-1:0] img_rdata,
    input  logic [WORD_W-1:0] w_rdata,
    output logic [WORD_W-1:0] acc_sat
);

    logic                     bias_vld_p0;
    logic                     vld_p0;
    logic                     vld_p1;
    logic signed [PROD_W-1:0] img_p0;
    logic signed [PROD_W-1:0] w_p0;
    logic signed [PROD_W-1:0] prod_p1;
    logic signed [ACC_W-1:0]  acc_p2;
    logic                     unused_hi;

    function automatic logic [WORD_W-1:0] sat_word(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[WORD_W-1:0];
        end
        if (v < SAT_MIN) begin
            return SAT_MIN[WORD_W-1:0];
        end
        return v[WORD_W-1:0];
    endfunction

    // Stage p0: read data returns one cycle after the address was issued.
    assign img_p0    = {{(PROD_W-DATA_W){img_rdata[DATA_W-1]}}, img_rdata[DATA_W-1:0]};
    assign w_p0      = {{(PROD_W-DATA_W){w_rdata[DATA_W-1]}}, w_rdata[DATA_W-1:0]};
    assign unused_hi = ^{img_rdata[WORD_W-1:DATA_W], w_rdata[WORD_W-1:DATA_W]};

    always_ff @(posedge clk) begin
        if (!reset_x) begin
            bias_vld_p0 <= 1'b0;
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            prod_p1     <= '0;
            acc_p2      <= '0;
        end else begin
            bias_vld_p0 <= bias_rd;
            vld_p0      <= mac_rd;
            vld_p1      <= vld_p0;
            // Stage p1: product register; the true product always fits in 32 bits.
            if (vld_p0) begin
                prod_p1 <= img_p0 * w_p0;
            end
            // Stage p2: the bias load and the first product of a class never coincide.
            if (bias_vld_p0) begin
                acc_p2 <= {{(ACC_W-WORD_W){bias_rdata[WORD_W-1]}}, bias_rdata};
            end else if (vld_p1) begin
                acc_p2 <= acc_p2 + {{(ACC_W-PROD_W){prod_p1[PROD_W-1]}}, prod_p1};
            end
        end
    end

    assign acc_sat = sat_word(acc_p2);

endmodule

// File: rtl/fc_mac_engine.sv
// Fully-connected layer engine: sequences bias/image/weight reads per class,
// drives the MAC datapath and writes one saturated Q16.16 result per class.
module fc_mac_engine import softmax_pkg::*; #(
    parameter  int N_IN    = 784,
    parameter  int N_OUT   = 10,
    localparam int IMG_AW  = addr_w(N_IN),
    localparam int W_AW    = addr_w(N_IN * N_OUT),
    localparam int BIAS_AW = addr_w(N_OUT)
) (
    input  logic               CLK,
    input  logic               RESET_X,
    input  logic               START,
    output logic               BUSY,
    output logic               DONE,
    output logic [IMG_AW-1:0]  IMG_ADR,
    input  logic [WORD_W-1:0]  IMG_RDATA,
    output logic [W_AW-1:0]    W_ADR,
    input  logic [WORD_W-1:0]  W_RDATA,
    output logic [BIAS_AW-1:0] BIAS_ADR,
    input  logic [WORD_W-1:0]  BIAS_RDATA,
    output logic               RES_WR,
    output logic [BIAS_AW-1:0] RES_IDX,
    output logic [WORD_W-1:0]  RES_DATA
);

    localparam logic [IMG_AW-1:0]  I_LAST = IMG_AW'(N_IN - 1);
    localparam logic [BIAS_AW-1:0] O_LAST = BIAS_AW'(N_OUT - 1);

    state_t              state;
    logic [IMG_AW-1:0]   i_cnt;
    logic [BIAS_AW-1:0]  o_cnt;
    logic [W_AW-1:0]     w_cnt;
    logic                drain_cnt;
    logic [WORD_W-1:0]   acc_sat;

    // Outputs are registered on entry to the state they belong to, so every
    // address and strobe is aligned with the state it is observed in.
    always_ff @(posedge CLK) begin
        if (!RESET_X) begin
            state     <= ST_IDLE;
            i_cnt     <= '0;
            o_cnt     <= '0;
            w_cnt     <= '0;
            drain_cnt <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            RES_WR    <= 1'b0;
            RES_IDX   <= '0;
            IMG_ADR   <= '0;
            W_ADR     <= '0;
            BIAS_ADR  <= '0;
        end else begin
            DONE     <= 1'b0;
            RES_WR   <= 1'b0;
            RES_IDX  <= '0;
            IMG_ADR  <= '0;
            W_ADR    <= '0;
            BIAS_ADR <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (START) begin
                        state <= ST_BIAS;
                        BUSY  <= 1'b1;
                        o_cnt <= '0;
                        w_cnt <= '0;
                    end
                end
                ST_BIAS: begin
                    state   <= ST_MAC;
                    i_cnt   <= '0;
                    IMG_ADR <= '0;
                    W_ADR   <= w_cnt;
                    w_cnt   <= w_cnt + 1'b1;
                end
                ST_MAC: begin
                    if (i_cnt == I_LAST) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 1'b0;
                    end else begin
                        i_cnt   <= i_cnt + 1'b1;
                        IMG_ADR <= i_cnt + 1'b1;
                        W_ADR   <= w_cnt;
                        w_cnt   <= w_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Two cycles: one for the read return, one for the product register.
                    if (drain_cnt) begin
                        state   <= ST_WRITE;
                        RES_WR  <= 1'b1;
                        RES_IDX <= o_cnt;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (o_cnt == O_LAST) begin
                        state <= ST_FIN;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end else begin
                        state    <= ST_BIAS;
                        o_cnt    <= o_cnt + 1'b1;
                        BIAS_ADR <= o_cnt + 1'b1;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    fc_mac_pipe u_pipe (
        .clk        (CLK),
        .reset_x    (RESET_X),
        .bias_rd    (state == ST_BIAS),
        .mac_rd     (state == ST_MAC),
        .bias_rdata (BIAS_RDATA),
        .img_rdata  (IMG_RDATA),
        .w_rdata    (W_RDATA),
        .acc_sat    (acc_sat)
    );

    assign RES_DATA = RES_WR ? acc_sat : '0;

endmodule

// File: doc/fc_mac_engine.md
FC_MAC_ENGINE -- requirements
Module: fc_mac_engine

Interface
REQ-001 The block SHALL have one clock CLK; reset RESET_X SHALL be synchronous and active-low.
REQ-002 Parameter N_IN, default 784: input vector length.
REQ-003 Parameter N_OUT, default 10: number of output classes.
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 RESET_X  in  1  synchronous active-low reset.
REQ-006 START  in  1  single-cycle request to begin one full inference pass.
REQ-007 BUSY  out  1  high from the cycle after START is accepted until DONE.
REQ-008 DONE  out  1  single-cycle pulse when all N_OUT results have been written.
REQ-009 IMG_ADR  out  clog2(N_IN)  image SRAM read address.
REQ-010 IMG_RDATA  in  32  image word; signed Q8.8 in bits[15:0]; valid 1 cycle after IMG_ADR.
REQ-011 W_ADR  out  clog2(N_IN*N_OUT)  weight SRAM read address, o*N_IN+i.
REQ-012 W_RDATA  in  32  weight word; signed Q8.8 in bits[15:0]; valid 1 cycle after W_ADR.
REQ-013 BIAS_ADR  out  clog2(N_OUT)  bias register-file read address.
REQ-014 BIAS_RDATA  in  32  signed Q16.16 bias; valid 1 cycle after BIAS_ADR.
REQ-015 RES_WR  out  1  result write strobe toward the CPU-interface result registers.
REQ-016 RES_IDX  out  clog2(N_OUT)  class index for RES_WR.
REQ-017 RES_DATA  out  32  signed Q16.16 result for RES_WR.

Function
REQ-018 States SHALL be IDLE, BIAS, MAC, DRAIN, WRITE, FIN.
REQ-019 In IDLE, START=1 SHALL move to BIAS with class counter o=0; START in any other state SHALL be ignored.
REQ-020 BIAS (1 cycle): drive BIAS_ADR=o; the accumulator SHALL load the sign-extended BIAS_RDATA on the following cycle.
REQ-021 MAC (N_IN cycles): drive IMG_ADR=i and W_ADR=o*N_IN+i for i=0..N_IN-1, one address pair per cycle, no bubbles.
REQ-022 Products SHALL be signed 16x16 into 32 bits, registered once, then added into a 48-bit signed accumulator.
REQ-023 DRAIN (2 cycles) SHALL flush the read and multiply stages, so every product is accumulated before WRITE.
REQ-024 WRITE (1 cycle): RES_WR=1, RES_IDX=o, RES_DATA=accumulator saturated to 32 bits (>0x7FFFFFFF -> 0x7FFFFFFF, <-0x80000000 -> 0x80000000).
REQ-025 After WRITE, o<N_OUT-1 SHALL increment o and go to BIAS; o=N_OUT-1 SHALL go to FIN.
REQ-026 FIN (1 cycle): DONE=1, BUSY=0, then IDLE; START is accepted again on the cycle after FIN.
REQ-027 Latency: START at cycle 0 -> first RES_WR at cycle N_IN+4 -> DONE at cycle N_OUT*(N_IN+4)+1.
REQ-028 RES_WR SHALL occur exactly N_OUT times per pass, in ascending RES_IDX order.
REQ-029 Addresses SHALL be 0 whenever their read is not in use.

Reset
REQ-030 RESET_X=0 at a clock edge SHALL force IDLE, BUSY=0, DONE=0, RES_WR=0, RES_IDX=0, RES_DATA=0, all addresses 0, accumulator, pipeline and counters 0.
REQ-031 Reset mid-pass SHALL abort without further RES_WR or DONE; a new START after release SHALL run a complete pass.

Structure
REQ-032 Shared package softmax_pkg SHALL hold the state enum, data widths (16/32/48) and the saturation limits.
REQ-033 Datapath SHALL be sub-module fc_mac_pipe (product register, accumulator, saturation); the FSM and address counters SHALL stay in fc_mac_engine.

Verification
REQ-034 N_IN=4, N_OUT=2, image all 0x0100, weights all 0x0100, bias 0 -> RES_DATA 0x00040000 for idx 0 and 1; DONE at cycle 17.
REQ-035 Default parameters, image 0x0100, weights class o = o<<8, bias 0x00010000 -> RES_DATA[o]=784*o*0x10000+0x10000; DONE at cycle 7881.
REQ-036 N_IN=4, image 0x7FFF, weights 0x7FFF, bias 0x7FFFFFFF -> RES_DATA 0x7FFFFFFF; weights 0x8000 with bias 0x80000000 -> RES_DATA 0x80000000.
REQ-037 START pulsed again at cycle 5 of a pass -> ignored; exactly N_OUT RES_WR and one DONE.
REQ-038 RESET_X low for 1 cycle during class 1 MAC -> no RES_WR or DONE afterwards; new START -> correct full pass.
REQ-039 START held high 3 cycles in IDLE -> exactly one pass started; DONE then START same cycle as FIN -> START ignored.
